// File: rtl/wei_arb_pkg.sv
// Shared types and sizing for the weight-address instruction arbiter.
// Instruction layout: [4:0] PE index, [7:5] burst length.
package wei_arb_pkg;

  localparam int unsigned NUM_PEB     = 16;
  localparam int unsigned PE_NUM      = 27;
  localparam int unsigned INSTR_WIDTH = 8;
  localparam int unsigned CNT_WIDTH   = 12;
  localparam int unsigned PEB_W       = $clog2(NUM_PEB);

  localparam int unsigned PE_IDX_LSB  = 0;
  localparam int unsigned PE_IDX_MSB  = 4;
  localparam int unsigned BURST_LSB   = 5;
  localparam int unsigned BURST_MSB   = 7;
  localparam int unsigned PE_IDX_W    = PE_IDX_MSB - PE_IDX_LSB + 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } arb_state_e;

  // (base + off) mod NUM_PEB, with off < NUM_PEB.
  function automatic logic [PEB_W-1:0] peb_wrap(logic [PEB_W-1:0] base, int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NUM_PEB) sum -= NUM_PEB;
    return PEB_W'(sum);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, searching cyclically.
module rr_pick
  import wei_arb_pkg::*;
(
  input  logic [NUM_PEB-1:0] req_i,
  input  logic [PEB_W-1:0]   ptr_i,
  output logic [PEB_W-1:0]   winner_o,
  output logic               any_o
);

  always_comb begin
    winner_o = '0;
    any_o    = 1'b0;
    for (int unsigned k = 0; k < NUM_PEB; k++) begin
      if (!any_o && req_i[peb_wrap(ptr_i, k)]) begin
        any_o    = 1'b1;
        winner_o = peb_wrap(ptr_i, k);
      end
    end
  end

endmodule

// File: rtl/wei_instr_arbiter.sv
// Round-robin arbiter feeding a single-entry instruction stage toward the weight-address block,
// counting issued instructions against a per-pass total.
module wei_instr_arbiter
  import wei_arb_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [CNT_WIDTH-1:0]           cfg_total,
  input  logic [NUM_PEB-1:0]             req_val,
  input  logic [NUM_PEB*INSTR_WIDTH-1:0] req_data,
  output logic [NUM_PEB-1:0]             req_rdy,
  output logic                           instr_val,
  input  logic                           instr_rdy,
  output logic [PEB_W-1:0]               instr_peb,
  output logic [INSTR_WIDTH-1:0]         instr_data,
  output logic                           pass_done,
  output logic                           busy,
  output logic                           err_pe_range
);

  arb_state_e             state_q;
  logic [PEB_W-1:0]       ptr_q;
  logic [CNT_WIDTH-1:0]   issued_q;
  logic [CNT_WIDTH-1:0]   total_q;
  logic                   instr_val_q;
  logic [PEB_W-1:0]       instr_peb_q;
  logic [INSTR_WIDTH-1:0] instr_data_q;
  logic                   pass_done_q;
  logic                   err_q;

  logic [PEB_W-1:0]       winner;
  logic                   any_req;
  logic [INSTR_WIDTH-1:0] win_data;
  logic [PE_IDX_W-1:0]    win_pe;
  logic                   pe_ok;
  logic                   xfer;
  logic                   load;

  rr_pick u_rr_pick (
    .req_i    (req_val),
    .ptr_i    (ptr_q),
    .winner_o (winner),
    .any_o    (any_req)
  );

  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < NUM_PEB; i++) begin
      if (PEB_W'(i) == winner) win_data = req_data[i*INSTR_WIDTH +: INSTR_WIDTH];
    end
    win_pe = win_data[PE_IDX_MSB:PE_IDX_LSB];
    pe_ok  = (32'(win_pe) < PE_NUM);
    xfer   = instr_val_q && instr_rdy;
    // start pre-empts any grant in the same cycle
    load   = !start && (state_q == StRun) && (issued_q < total_q) && any_req &&
             (!instr_val_q || instr_rdy);
    req_rdy = '0;
    if (load) req_rdy[winner] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      issued_q     <= '0;
      total_q      <= '0;
      instr_val_q  <= 1'b0;
      instr_peb_q  <= '0;
      instr_data_q <= '0;
      pass_done_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      pass_done_q <= 1'b0;
      if (start) begin
        issued_q     <= '0;
        total_q      <= cfg_total;
        ptr_q        <= '0;
        instr_val_q  <= 1'b0;
        instr_peb_q  <= '0;
        instr_data_q <= '0;
        err_q        <= 1'b0;
        if (cfg_total == '0) begin
          state_q     <= StIdle;
          pass_done_q <= 1'b1;
        end else begin
          state_q <= StRun;
        end
      end else begin
        if (xfer) instr_val_q <= 1'b0;
        unique case (state_q)
          StIdle: ;
          StRun: begin
            if (load) begin
              ptr_q <= peb_wrap(winner, 1);
              if (pe_ok) begin
                instr_val_q  <= 1'b1;
                instr_peb_q  <= winner;
                instr_data_q <= win_data;
                issued_q     <= issued_q + CNT_WIDTH'(1);
                if (issued_q + CNT_WIDTH'(1) == total_q) state_q <= StDrain;
              end else begin
                // dropped instruction is consumed but never counted
                err_q <= 1'b1;
              end
            end
          end
          StDrain: begin
            if (!instr_val_q || xfer) begin
              state_q     <= StIdle;
              pass_done_q <= 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign instr_val    = instr_val_q;
  assign instr_peb    = instr_peb_q;
  assign instr_data   = instr_data_q;
  assign pass_done    = pass_done_q;
  assign busy         = (state_q != StIdle);
  assign err_pe_range = err_q;

endmodule

// File: tb/tb_wei_instr_arbiter.sv
// Scoreboard bench for wei_instr_arbiter: expected forwarded instructions are queued as grants
// are expected and popped when a transfer is seen on the output port.
module tb_wei_instr_arbiter;
  import wei_arb_pkg::*;

  logic                           clk;
  logic                           rst_n;
  logic                           start;
  logic [CNT_WIDTH-1:0]           cfg_total;
  logic [NUM_PEB-1:0]             req_val;
  logic [NUM_PEB*INSTR_WIDTH-1:0] req_data;
  logic [NUM_PEB-1:0]             req_rdy;
  logic                           instr_val;
  logic                           instr_rdy;
  logic [PEB_W-1:0]               instr_peb;
  logic [INSTR_WIDTH-1:0]         instr_data;
  logic                           pass_done;
  logic                           busy;
  logic                           err_pe_range;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [PEB_W+INSTR_WIDTH-1:0] sb[$];
  logic [INSTR_WIDTH-1:0]       req_words [NUM_PEB];

  wei_instr_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .cfg_total    (cfg_total),
    .req_val      (req_val),
    .req_data     (req_data),
    .req_rdy      (req_rdy),
    .instr_val    (instr_val),
    .instr_rdy    (instr_rdy),
    .instr_peb    (instr_peb),
    .instr_data   (instr_data),
    .pass_done    (pass_done),
    .busy         (busy),
    .err_pe_range (err_pe_range)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [INSTR_WIDTH-1:0] mk(input int unsigned burst, input int unsigned pe);
    return {3'(burst), 5'(pe)};
  endfunction

  task automatic set_req(input int unsigned peb, input logic [INSTR_WIDTH-1:0] d);
    req_words[peb] = d;
    req_data[peb*INSTR_WIDTH +: INSTR_WIDTH] = d;
  endtask

  // Called at a negedge: expect a grant to PEB g, queue its forwarded value, advance.
  task automatic grant_chk(input int unsigned g);
    check_eq("grant", 32'(req_rdy), 32'(1) << g);
    sb.push_back({PEB_W'(g), req_words[g]});
    tick();
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_req_rdy"}, 32'(req_rdy), 0);
    check_eq({tag, "_instr_val"}, 32'(instr_val), 0);
    check_eq({tag, "_instr_peb"}, 32'(instr_peb), 0);
    check_eq({tag, "_instr_data"}, 32'(instr_data), 0);
    check_eq({tag, "_pass_done"}, 32'(pass_done), 0);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_err"}, 32'(err_pe_range), 0);
  endtask

  // Transfer monitor: every accepted output word must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && instr_val && instr_rdy) begin
      if (sb.size() == 0) begin
        check_eq("sb_unexpected_xfer", {20'd0, instr_peb, instr_data}, 32'hFFFF_FFFF);
      end else begin
        check_eq("sb_xfer", {20'd0, instr_peb, instr_data}, 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; cfg_total = '0; req_val = '0; req_data = '0; instr_rdy = 1'b0;
    for (int i = 0; i < int'(NUM_PEB); i++) req_words[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    #2 rst_n = 1'b1;
    tick();

    // Basic pass: grants 0,3,7,0 then drain and pass_done.
    set_req(0, mk(1, 5)); set_req(3, mk(2, 5)); set_req(7, mk(3, 5));
    req_val = 16'h0089; instr_rdy = 1'b1; cfg_total = 12'd4; start = 1'b1;
    @(negedge clk);
    check_eq("start_no_grant", 32'(req_rdy), 0);
    tick(); start = 1'b0;
    @(negedge clk); check_eq("run_busy", 32'(busy), 1); grant_chk(0);
    @(negedge clk); grant_chk(3);
    @(negedge clk); grant_chk(7);
    @(negedge clk); check_eq("no_early_done", 32'(pass_done), 0); grant_chk(0);
    @(negedge clk);
    check_eq("drain_no_grant", 32'(req_rdy), 0);
    check_eq("drain_no_done", 32'(pass_done), 0);
    check_eq("drain_busy", 32'(busy), 1);
    tick();
    @(negedge clk);
    check_eq("pass_done", 32'(pass_done), 1);
    check_eq("idle_busy", 32'(busy), 0);
    check_eq("sb_empty_pass", sb.size(), 0);
    tick();
    @(negedge clk);
    check_eq("pass_done_single", 32'(pass_done), 0);

    // Backpressure with a burst-length-0 instruction.
    req_val = '0; set_req(2, mk(4, 10)); set_req(5, mk(0, 3));
    req_val = 16'h0024; instr_rdy = 1'b0; cfg_total = 12'd3; start = 1'b1;
    tick(); start = 1'b0;
    @(negedge clk); grant_chk(2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("bp_no_grant", 32'(req_rdy), 0);
      check_eq("bp_val", 32'(instr_val), 1);
      check_eq("bp_peb", 32'(instr_peb), 2);
      check_eq("bp_data", 32'(instr_data), 32'(mk(4, 10)));
      tick();
    end
    instr_rdy = 1'b1;
    @(negedge clk); grant_chk(5);
    @(negedge clk); grant_chk(2);
    @(negedge clk); check_eq("bp_drain", 32'(req_rdy), 0); tick();
    @(negedge clk); check_eq("bp_done", 32'(pass_done), 1); tick();

    // Out-of-range PE index is consumed, flagged and not counted.
    req_val = '0; set_req(9, mk(4, 27));
    req_val = 16'h0200; cfg_total = 12'd2; start = 1'b1;
    tick(); start = 1'b0;
    @(negedge clk);
    check_eq("bad_consumed", 32'(req_rdy), 32'h0200);
    tick();
    set_req(9, mk(5, 26));
    @(negedge clk);
    check_eq("bad_not_fwd", 32'(instr_val), 0);
    check_eq("bad_err", 32'(err_pe_range), 1);
    grant_chk(9);
    @(negedge clk); grant_chk(9);
    @(negedge clk); check_eq("bad_drain", 32'(req_rdy), 0); tick();
    @(negedge clk);
    check_eq("bad_done", 32'(pass_done), 1);
    check_eq("err_sticky", 32'(err_pe_range), 1);
    tick();

    // Zero total: immediate completion, no grants.
    req_val = 16'h00FF; cfg_total = '0; start = 1'b1;
    @(negedge clk); check_eq("zero_no_grant0", 32'(req_rdy), 0);
    tick(); start = 1'b0;
    @(negedge clk);
    check_eq("zero_done", 32'(pass_done), 1);
    check_eq("zero_busy", 32'(busy), 0);
    check_eq("zero_no_grant1", 32'(req_rdy), 0);
    check_eq("err_cleared", 32'(err_pe_range), 0);
    tick();
    @(negedge clk);
    check_eq("zero_done_single", 32'(pass_done), 0);
    check_eq("zero_no_grant2", 32'(req_rdy), 0);
    tick();

    // Abort during DRAIN: stage cleared, pointer back to 0, no completion pulse.
    req_val = '0; set_req(4, mk(2, 0));
    req_val = 16'h0010; instr_rdy = 1'b0; cfg_total = 12'd1; start = 1'b1;
    tick(); start = 1'b0;
    @(negedge clk); grant_chk(4);
    @(negedge clk);
    check_eq("abort_drain_val", 32'(instr_val), 1);
    check_eq("abort_drain_busy", 32'(busy), 1);
    sb.delete();
    tick();
    set_req(1, mk(6, 12)); set_req(14, mk(7, 20));
    req_val = 16'h4002; cfg_total = 12'd2; start = 1'b1;
    @(negedge clk); check_eq("abort_start_no_grant", 32'(req_rdy), 0);
    tick(); start = 1'b0; instr_rdy = 1'b1;
    @(negedge clk);
    check_eq("abort_cleared", 32'(instr_val), 0);
    check_eq("abort_no_done", 32'(pass_done), 0);
    grant_chk(1);
    @(negedge clk); grant_chk(14);
    @(negedge clk); check_eq("abort2_no_done", 32'(pass_done), 0); tick();
    @(negedge clk); check_eq("abort2_done", 32'(pass_done), 1); tick();

    // Asynchronous reset mid-RUN.
    req_val = '0; set_req(0, mk(1, 1)); set_req(1, mk(2, 2));
    req_val = 16'h0003; cfg_total = 12'd5; start = 1'b1;
    tick(); start = 1'b0;
    @(negedge clk); grant_chk(0);
    @(negedge clk);
    check_eq("pre_rst_grant", 32'(req_rdy), 32'h0002);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("async_rst");
    check_eq("rst_sb_empty", sb.size(), 0);
    @(negedge clk); check_eq("rst_no_done", 32'(pass_done), 0);
    #2 rst_n = 1'b1;
    tick();
    @(negedge clk);
    check_eq("post_rst_idle_rdy", 32'(req_rdy), 0);
    check_eq("post_rst_busy", 32'(busy), 0);
    tick();
    cfg_total = 12'd1; start = 1'b1;
    tick(); start = 1'b0;
    @(negedge clk); grant_chk(0);
    @(negedge clk); check_eq("post_rst_drain", 32'(req_rdy), 0); tick();
    @(negedge clk);
    check_eq("post_rst_done", 32'(pass_done), 1);
    check_eq("sb_empty_end", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wei_instr_arbiter.md
# wei_instr_arbiter

Round-robin arbiter and pass sequencer for the global-buffer weight-address instruction port. Up to NUM_PEB PE blocks each present a weight-fetch instruction (PE index plus burst length). This block selects one requester per cycle, registers it into a single-entry output stage, and forwards it with its PEB index to the weight-address block. It also counts issued instructions against a per-pass total and signals pass completion.

## Interface
- NUM_PEB, 16, number of requesting PE blocks
- PE_NUM, 27, PEs per PEB; valid PE index range is 0..PE_NUM-1
- INSTR_WIDTH, 8, instruction width; [4:0] = PE index, [7:5] = burst length
- CNT_WIDTH, 12, width of the pass instruction counter
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle pulse; begins a new pass; aborts any pass in progress
- cfg_total  in  CNT_WIDTH  instructions to issue in the pass; sampled on start
- req_val  in  NUM_PEB  per-PEB instruction valid
- req_data  in  NUM_PEB*INSTR_WIDTH  per-PEB instruction; PEB i occupies bits [i*INSTR_WIDTH +: INSTR_WIDTH]
- req_rdy  out  NUM_PEB  per-PEB accept; one-hot or zero
- instr_val  out  1  instruction valid toward the weight-address block
- instr_rdy  in  1  weight-address block ready (low during bursts)
- instr_peb  out  4  PEB index of the forwarded instruction
- instr_data  out  INSTR_WIDTH  forwarded instruction
- pass_done  out  1  single-cycle pulse when the pass completes
- busy  out  1  high in RUN or DRAIN
- err_pe_range  out  1  sticky: an out-of-range PE index was dropped; cleared on start

## Operation
- FSM states:
  - IDLE: no grants.
  - RUN: arbitrate.
  - DRAIN: total reached; wait for the output stage to empty.
- start, in any state: issued counter ← 0, total ← cfg_total, RR pointer ← 0, output stage cleared (instr_val←0), err_pe_range←0.
  - Next state is RUN.
  - If cfg_total==0, next state is IDLE and pass_done pulses the following cycle.
- Load condition: state==RUN, issued<total, at least one req_val high, and output stage free. The stage is free when instr_val==0, or when instr_val&&instr_rdy in the same cycle.
- Winner: the first i with req_val[i], searching cyclically from ptr. req_rdy[winner] is driven combinationally on load; all other bits are 0.
- On load:
  - ptr ← (winner+1) mod NUM_PEB.
  - If req_data[4:0] < PE_NUM: output stage ← {winner, req_data}, instr_val←1, issued ← issued+1.
  - Otherwise: the instruction is consumed but not forwarded and not counted; err_pe_range←1.
- Output stage holds its value while instr_val && !instr_rdy. Transfer occurs when instr_val && instr_rdy.
- RUN→DRAIN when the load makes issued==total.
- DRAIN→IDLE once instr_val==0 or a transfer occurs; pass_done pulses in that transition cycle.
- A burst length of 0 is forwarded unchanged; the downstream block interprets it.

## Timing
- Reset values: req_rdy=0, instr_val=0, instr_peb=0, instr_data=0, pass_done=0, busy=0, err_pe_range=0; state=IDLE, ptr=0, issued=0.
- Latency: 1 cycle from the req_val&req_rdy handshake to instr_val.
- Throughput: 1 instruction/cycle while instr_rdy stays high.
- start coinciding with a load: start wins; no grant is issued that cycle.
- start during DRAIN: no pass_done for the aborted pass.
- issued never exceeds total; req_rdy=0 in DRAIN and IDLE.
- Asynchronous reset mid-pass: all state returns to reset values immediately; no pass_done.

## Structure
- Package wei_arb_pkg holds:
  - state enum (IDLE, RUN, DRAIN)
  - NUM_PEB, PE_NUM, INSTR_WIDTH, field positions PE_IDX_LSB/MSB and BURST_LSB/MSB
- Sub-module rr_pick (combinational): inputs req vector and ptr; outputs winner index and any-valid.

## Test plan
- Pass setup: start with cfg_total=4; PEBs 0, 3, 7 hold req_val with PE index 5, instr_rdy=1.
  - Grants go 0,3,7,0, one per cycle.
  - instr_peb sequence is 0,3,7,0.
  - pass_done pulses one cycle after the last transfer; PEB 3 is not granted a second time.
- Backpressure: instr_rdy low for 3 cycles with instr_val high.
  - instr_peb and instr_data stay stable; req_rdy stays 0.
  - Transfer occurs on the cycle instr_rdy rises, with a new load in that same cycle.
- Range error: a PEB sends PE index 27.
  - req_rdy pulses and instr_val stays 0; issued is unchanged; err_pe_range=1 until the next start.
- Zero total: start with cfg_total=0.
  - No req_rdy is asserted; pass_done pulses the next cycle; busy=0.
- Abort: start during DRAIN, and asynchronous rst_n mid-RUN.
  - Output stage is cleared, ptr=0, and there is no pass_done for the aborted pass.
  - After rst_n, all outputs return to reset values.
